// File: rtl/alu_wb.sv
// ---------------------------------------------------------------------------
// alu_wb -- ALU result writeback buffer
//
// Purpose:
//   This is the return path for operands that the operand-gating stage
//   passes into the ALU. ALU results arrive with a destination register
//   index and a carry bit. They wait in a small FIFO and leave one per
//   accepted register-file write. The Z/N/C flags are updated from each
//   entry as it retires. The newest pending entry is also exposed as a
//   bypass source for operand fetch.
//
// Parameters:
//   DW     result / register data width
//   AW     register index width
//   DEPTH  FIFO entries (power of two, >= 2)
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous reset, active-low
//   res_valid  in   1   ALU result present this cycle
//   res_ready  out  1   buffer can accept a result
//   res_data   in   DW  ALU result
//   res_dst    in   AW  destination register index
//   res_cy     in   1   ALU carry-out for this result
//   flush      in   1   synchronous discard of all pending entries
//   wb_en      out  1   register-file write request (head entry valid)
//   wb_addr    out  AW  head entry destination index
//   wb_data    out  DW  head entry data
//   wb_ack     in   1   register file accepts the write this cycle
//   flag_z     out  1   last retired result was zero
//   flag_n     out  1   last retired result MSB
//   flag_c     out  1   last retired result carry
//   fwd_valid  out  1   at least one entry pending
//   fwd_addr   out  AW  destination index of newest pending entry
//   fwd_data   out  DW  data of newest pending entry
// ---------------------------------------------------------------------------
module alu_wb #(
    parameter int DW    = 16,
    parameter int AW    = 3,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          res_valid,
    output logic          res_ready,
    input  logic [DW-1:0] res_data,
    input  logic [AW-1:0] res_dst,
    input  logic          res_cy,
    input  logic          flush,
    output logic          wb_en,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data,
    input  logic          wb_ack,
    output logic          flag_z,
    output logic          flag_n,
    output logic          flag_c,
    output logic          fwd_valid,
    output logic [AW-1:0] fwd_addr,
    output logic [DW-1:0] fwd_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] dst;
        logic [DW-1:0] data;
        logic          cy;
    } entry_t;

    // Storage and bookkeeping
    entry_t        mem_reg [DEPTH];
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0] count_reg,  count_next;
    logic          flag_z_reg, flag_z_next;
    logic          flag_n_reg, flag_n_next;
    logic          flag_c_reg, flag_c_next;

    logic          push;
    logic          pop;
    logic [PW-1:0] newest_ptr;
    entry_t        head;
    entry_t        newest;

    // Handshake decode. Both signals depend only on the registered count.
    // A pop in the same cycle therefore cannot reopen a full buffer, and no
    // input reaches an output combinationally.
    assign res_ready = (count_reg != CW'(DEPTH));
    assign wb_en     = (count_reg != '0);

    // A flush drops any push or pop presented in the same cycle.
    assign push = res_valid & res_ready & ~flush;
    assign pop  = wb_en & wb_ack & ~flush;

    // The head is the oldest entry. The newest entry sits just behind the
    // write pointer, and the subtraction wraps modulo DEPTH.
    assign head       = mem_reg[rd_ptr_reg];
    assign newest_ptr = wr_ptr_reg - PW'(1);
    assign newest     = mem_reg[newest_ptr];

    // When the buffer is empty, the stored contents are stale. The outputs
    // are forced to zero in that case.
    assign wb_addr   = wb_en ? head.dst    : '0;
    assign wb_data   = wb_en ? head.data   : '0;
    assign fwd_valid = wb_en;
    assign fwd_addr  = wb_en ? newest.dst  : '0;
    assign fwd_data  = wb_en ? newest.data : '0;

    assign flag_z = flag_z_reg;
    assign flag_n = flag_n_reg;
    assign flag_c = flag_c_reg;

    // Next-state logic for pointers, count and flags
    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        flag_z_next = flag_z_reg;
        flag_n_next = flag_n_reg;
        flag_c_next = flag_c_reg;

        if (flush) begin
            // Flags are intentionally left alone: they describe retirements,
            // and a flush retires nothing.
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
                flag_z_next = (head.data == '0);
                flag_n_next = head.data[DW-1];
                flag_c_next = head.cy;
            end
            unique case ({push, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            flag_z_reg <= 1'b0;
            flag_n_reg <= 1'b0;
            flag_c_reg <= 1'b0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            flag_z_reg <= flag_z_next;
            flag_n_reg <= flag_n_next;
            flag_c_reg <= flag_c_next;
        end
    end

    // Entry storage. The array is small and its head and newest entries are
    // read combinationally, so it is built from flops rather than block RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (push) begin
            mem_reg[wr_ptr_reg] <= '{dst: res_dst, data: res_data, cy: res_cy};
        end
    end

endmodule

// File: tb/tb_alu_wb.sv
// ---------------------------------------------------------------------------
// tb_alu_wb -- directed scoreboard testbench for alu_wb
//
// Stimulus is applied 1 time unit after each rising edge. Each accepted
// result is queued with its expected (addr, data). A monitor process runs on
// every falling edge. Whenever a write is being accepted, it pops the queue
// and compares. Point checks of flags and handshake signals are made from
// the driver, also away from the active edge.
// ---------------------------------------------------------------------------
module tb_alu_wb;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic [AW-1:0] res_dst;
    logic          res_cy;
    logic          flush;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          wb_ack;
    logic          flag_z, flag_n, flag_c;
    logic          fwd_valid;
    logic [AW-1:0] fwd_addr;
    logic [DW-1:0] fwd_data;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    alu_wb #(.DW(DW), .AW(AW), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_dst   (res_dst),
        .res_cy    (res_cy),
        .flush     (flush),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_ack    (wb_ack),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .fwd_valid (fwd_valid),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a result for the next edge; queue it only if it is expected to be accepted.
    task automatic drive(input logic [DW-1:0] d, input logic [AW-1:0] a, input logic c,
                         input bit expect_accept);
        res_valid = 1'b1;
        res_data  = d;
        res_dst   = a;
        res_cy    = c;
        if (expect_accept) sb.push_back('{addr: a, data: d});
    endtask

    task automatic idle_res();
        res_valid = 1'b0;
        res_data  = '0;
        res_dst   = '0;
        res_cy    = 1'b0;
    endtask

    // Monitor: one line per accepted register-file write
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && !flush && wb_en && wb_ack) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL wb_unexpected: got (%0d,0x%04h) expected no write", wb_addr, wb_data);
                end else begin
                    e = sb.pop_front();
                    if (wb_addr !== e.addr || wb_data !== e.data) begin
                        n_err++;
                        $display("FAIL wb_order: got (%0d,0x%04h) expected (%0d,0x%04h)",
                                 wb_addr, wb_data, e.addr, e.data);
                    end else begin
                        $display("wb write addr=%0d data=0x%04h", wb_addr, wb_data);
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        wb_ack = 1'b0;
        idle_res();

        // 1: reset with res_valid held high
        res_valid = 1'b1;
        res_data  = 16'h1234;
        res_dst   = 3'd1;
        #3;
        check("rst_res_ready", res_ready, 1);
        check("rst_wb_en", wb_en, 0);
        check("rst_flags", {flag_z, flag_n, flag_c}, 3'b000);
        check("rst_fwd_valid", fwd_valid, 0);
        step();
        step();
        check("rst_hold_wb_en", wb_en, 0);
        check("rst_wb_bus", {wb_addr, wb_data, fwd_addr, fwd_data}, 0);
        idle_res();
        rst = 1'b1;
        step();

        // 2: single result, zero data with carry
        drive(16'h0000, 3'd3, 1'b1, 1);
        wb_ack = 1'b1;
        step();
        idle_res();
        check("t2_wb_en", wb_en, 1);
        check("t2_wb_addr", wb_addr, 3);
        check("t2_wb_data", wb_data, 16'h0000);
        check("t2_fwd", {fwd_valid, fwd_addr}, {1'b1, 3'd3});
        step();
        check("t2_flags_zc", {flag_z, flag_n, flag_c}, 3'b101);
        check("t2_empty", wb_en, 0);
        check("t2_fwd_empty", {fwd_valid, fwd_addr, fwd_data}, 0);

        // 3: fill with no acks; a push into the full buffer is ignored
        wb_ack = 1'b0;
        drive(16'h1234, 3'd1, 1'b0, 1);
        step();
        drive(16'h8000, 3'd2, 1'b0, 1);
        step();
        check("t3_full_ready", res_ready, 0);
        check("t3_fwd_addr", fwd_addr, 2);
        check("t3_fwd_data", fwd_data, 16'h8000);
        check("t3_head", {wb_addr, wb_data}, {3'd1, 16'h1234});
        drive(16'hFFFF, 3'd7, 1'b1, 0);
        step();
        check("t3_ignored_ready", res_ready, 0);
        check("t3_ignored_fwd", {fwd_addr, fwd_data}, {3'd2, 16'h8000});
        check("t3_head_stable", {wb_addr, wb_data}, {3'd1, 16'h1234});
        check("t3_flags_hold", {flag_z, flag_n, flag_c}, 3'b101);
        idle_res();
        wb_ack = 1'b1;
        step();
        check("t3_flags_1234", {flag_z, flag_n, flag_c}, 3'b000);
        check("t3_ready_reopen", res_ready, 1);
        step();
        check("t3_flags_8000", {flag_z, flag_n, flag_c}, 3'b010);
        check("t3_drained", wb_en, 0);
        wb_ack = 1'b0;

        // 4: push and pop together keep the count steady
        drive(16'h0005, 3'd4, 1'b0, 1);
        step();
        drive(16'h0006, 3'd5, 1'b1, 1);
        wb_ack = 1'b1;
        step();
        check("t4_count_ready", res_ready, 1);
        check("t4_next_head", {wb_en, wb_addr, wb_data}, {1'b1, 3'd5, 16'h0006});
        check("t4_flags_0005", {flag_z, flag_n, flag_c}, 3'b000);
        for (int i = 0; i < 10; i++) begin
            drive(16'h0100 + 16'(i), 3'(i), 1'(i), 1);
            step();
            check("t4_loop_ready", res_ready, 1);
            check("t4_loop_head", wb_data, 16'h0100 + 16'(i));
            check("t4_loop_fwd", {fwd_addr, fwd_data}, {3'(i), 16'h0100 + 16'(i)});
        end
        idle_res();
        step();
        check("t4_drained", wb_en, 0);
        check("t4_flags_last", {flag_z, flag_n, flag_c}, 3'b001);
        wb_ack = 1'b0;

        // 5a: flush with 2 pending, push attempt and ack in the same cycle
        drive(16'h00AA, 3'd1, 1'b0, 1);
        step();
        drive(16'h8BBB, 3'd2, 1'b0, 1);
        step();
        drive(16'h0000, 3'd3, 1'b0, 0);
        wb_ack = 1'b1;
        flush = 1'b1;
        sb.delete();
        step();
        flush = 1'b0;
        wb_ack = 1'b0;
        idle_res();
        check("t5_wb_en", wb_en, 0);
        check("t5_ready", res_ready, 1);
        check("t5_flags_hold", {flag_z, flag_n, flag_c}, 3'b001);
        // 5b: flush beats an acceptable push and a real pop
        drive(16'h0077, 3'd6, 1'b0, 1);
        step();
        drive(16'h0000, 3'd7, 1'b0, 0);
        wb_ack = 1'b1;
        flush = 1'b1;
        sb.delete();
        step();
        flush = 1'b0;
        wb_ack = 1'b0;
        idle_res();
        check("t5b_wb_en", wb_en, 0);
        check("t5b_flags_hold", {flag_z, flag_n, flag_c}, 3'b001);

        // 6: asynchronous reset mid-drain
        drive(16'h4000, 3'd3, 1'b0, 1);
        step();
        drive(16'h0001, 3'd4, 1'b1, 1);
        step();
        idle_res();
        wb_ack = 1'b1;
        step();
        check("t6_flags_4000", {flag_z, flag_n, flag_c}, 3'b000);
        check("t6_pending", {wb_en, wb_addr, wb_data}, {1'b1, 3'd4, 16'h0001});
        #2;
        rst = 1'b0;
        sb.delete();
        #1;
        check("t6_async_wb_en", wb_en, 0);
        check("t6_async_ready", res_ready, 1);
        check("t6_async_fwd", fwd_valid, 0);
        step();
        wb_ack = 1'b0;
        rst = 1'b1;
        step();
        check("t6_after_wb_en", wb_en, 0);
        check("t6_after_flags", {flag_z, flag_n, flag_c}, 3'b000);
        check("sb_empty_end", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
